// File: rtl/idu_pkg.sv
// Shared decode types for the instruction-decode stage: opcodes, ALU ops, immediate formats, control bundle.
// Latency: n/a (types and a pure helper function only).
// Backpressure: n/a.
package idu_pkg;

  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;

  typedef enum logic [3:0] {
    ALU_ADD      = 4'd0,
    ALU_SUB      = 4'd1,
    ALU_SLL      = 4'd2,
    ALU_SLT      = 4'd3,
    ALU_SLTU     = 4'd4,
    ALU_XOR      = 4'd5,
    ALU_SRL      = 4'd6,
    ALU_SRA      = 4'd7,
    ALU_OR       = 4'd8,
    ALU_AND      = 4'd9,
    ALU_LUI_PASS = 4'd10
  } alu_op_e;

  typedef enum logic [2:0] {
    IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J
  } imm_type_e;

  // Narrow control part of a decoded instruction; wide operands travel beside it.
  typedef struct packed {
    logic [4:0] rd;
    alu_op_e    alu_op;
    logic       jump;
    logic       branch;
    logic       load;
    logic       store;
    logic       wen;
    logic       word;
    logic       ebreak;
    logic       illegal;
  } dec_ctrl_t;

  // funct3 -> ALU op; alt is inst[30] (SUB only for register ops, SRA for both).
  function automatic alu_op_e alu_op_from_f3(input logic [2:0] f3, input logic alt,
                                             input logic is_reg);
    alu_op_e op;
    case (f3)
      3'b000:  op = (is_reg && alt) ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/idu_dec.sv
// Combinational RV32I/RV64I decoder: inst/pc/pc_s/src1/src2 in -> control bundle, four operands, imm out.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller registers the result.
import idu_pkg::*;

module idu_dec #(
  parameter int DATA_LEN = 32
) (
  input  logic [31:0]         inst,
  input  logic [DATA_LEN-1:0] pc,
  input  logic [DATA_LEN-1:0] pc_s,
  input  logic [DATA_LEN-1:0] src1,
  input  logic [DATA_LEN-1:0] src2,
  output dec_ctrl_t           ctrl,
  output logic [DATA_LEN-1:0] operand1,
  output logic [DATA_LEN-1:0] operand2,
  output logic [DATA_LEN-1:0] operand3,
  output logic [DATA_LEN-1:0] operand4,
  output logic [DATA_LEN-1:0] imm
);

  localparam bit RV64 = (DATA_LEN == 64);

  logic [6:0]  opcode;
  logic [2:0]  f3;
  logic [4:0]  rd;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  imm_type_e   imm_type;
  logic        wb, illegal, is_load, is_store;

  assign opcode = inst[6:0];
  assign f3     = inst[14:12];
  assign rd     = inst[11:7];

  assign imm_i = {{20{inst[31]}}, inst[31:20]};
  assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign imm_u = {inst[31:12], 12'b0};
  assign imm_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

  // Sign-extending size cast; a no-op when DATA_LEN is 32.
  function automatic logic [DATA_LEN-1:0] sext(input logic [31:0] v);
    return DATA_LEN'($signed(v));
  endfunction

  always_comb begin
    case (opcode)
      OPC_LUI, OPC_AUIPC:                         imm_type = IMM_U;
      OPC_JAL:                                    imm_type = IMM_J;
      OPC_JALR, OPC_LOAD, OPC_OP_IMM, OPC_OP_IMM_32: imm_type = IMM_I;
      OPC_BRANCH:                                 imm_type = IMM_B;
      OPC_STORE:                                  imm_type = IMM_S;
      default:                                    imm_type = IMM_NONE;
    endcase
    case (imm_type)
      IMM_I:   imm = sext(imm_i);
      IMM_S:   imm = sext(imm_s);
      IMM_B:   imm = sext(imm_b);
      IMM_U:   imm = sext(imm_u);
      IMM_J:   imm = sext(imm_j);
      default: imm = '0;
    endcase
  end

  assign operand4 = (imm_type inside {IMM_I, IMM_U, IMM_J, IMM_B}) ? imm : '0;

  always_comb begin
    ctrl     = '0;
    operand1 = src1;
    operand2 = '0;
    operand3 = pc;
    wb       = 1'b0;
    illegal  = 1'b0;
    is_load  = 1'b0;
    is_store = 1'b0;
    case (opcode)
      OPC_LUI: begin
        operand1    = '0;
        operand2    = imm;
        ctrl.alu_op = ALU_LUI_PASS;
        wb          = 1'b1;
      end
      OPC_AUIPC: begin
        operand1 = pc;
        operand2 = imm;
        wb       = 1'b1;
      end
      // Link value is operand1+operand2 (pc_s+0); target is operand3+operand4.
      OPC_JAL: begin
        operand1  = pc_s;
        ctrl.jump = 1'b1;
        wb        = 1'b1;
      end
      OPC_JALR: begin
        operand1  = pc_s;
        operand3  = src1;
        ctrl.jump = 1'b1;
        wb        = 1'b1;
      end
      OPC_BRANCH: begin
        operand2    = src2;
        ctrl.branch = 1'b1;
        ctrl.alu_op = f3[2] ? (f3[1] ? ALU_SLTU : ALU_SLT) : ALU_SUB;
        illegal     = (f3[2:1] == 2'b01);
      end
      OPC_LOAD: begin
        operand2 = imm;
        is_load  = 1'b1;
        wb       = 1'b1;
        // lb/lh/lw/lbu/lhu always; ld/lwu only on RV64; funct3=111 never.
        illegal  = (f3 == 3'b111) || (!RV64 && (f3 == 3'b011 || f3 == 3'b110));
      end
      OPC_STORE: begin
        operand2 = imm;
        is_store = 1'b1;
        illegal  = f3[2] || (!RV64 && f3 == 3'b011);
      end
      OPC_OP_IMM: begin
        operand2    = imm;
        ctrl.alu_op = alu_op_from_f3(f3, inst[30], 1'b0);
        wb          = 1'b1;
      end
      OPC_OP: begin
        operand2    = src2;
        ctrl.alu_op = alu_op_from_f3(f3, inst[30], 1'b1);
        wb          = 1'b1;
      end
      OPC_OP_IMM_32: begin
        operand2    = imm;
        ctrl.alu_op = alu_op_from_f3(f3, inst[30], 1'b0);
        ctrl.word   = 1'b1;
        wb          = 1'b1;
        illegal     = !RV64;
      end
      OPC_OP_32: begin
        operand2    = src2;
        ctrl.alu_op = alu_op_from_f3(f3, inst[30], 1'b1);
        ctrl.word   = 1'b1;
        wb          = 1'b1;
        illegal     = !RV64;
      end
      OPC_SYSTEM:   ctrl.ebreak = (inst == INST_EBREAK);
      OPC_MISC_MEM: ;
      default:      illegal = 1'b1;
    endcase
    if (inst[1:0] != 2'b11) illegal = 1'b1;
    ctrl.rd      = rd;
    ctrl.illegal = illegal;
    ctrl.wen     = wb && (rd != 5'd0) && !illegal;
    ctrl.load    = is_load && !illegal;
    ctrl.store   = is_store && !illegal;
  end

endmodule

// File: rtl/idu_pipe.sv
// Decode stage: decodes in_inst with captured src1/src2 and registers the result (main + optional skid entry).
// Latency: 1 cycle from in_valid&&in_ready to out_valid.
// Backpressure: SKID_EN=1 gives a registered in_ready (= no skid entry held); SKID_EN=0 passes out_ready through.
// Ports: clk/rst (sync, active-high); in_* handshake + payload; rs1/rs2 regfile read addr; src1/src2 read data;
//        flush; out_* handshake, operands, imm, alu op and flags; halt (sticky after a consumed ebreak).
import idu_pkg::*;

module idu_pipe #(
  parameter int DATA_LEN = 32,
  parameter int SKID_EN  = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [31:0]         in_inst,
  input  logic [DATA_LEN-1:0] in_pc,
  input  logic [DATA_LEN-1:0] in_pc_s,
  output logic [4:0]          rs1,
  output logic [4:0]          rs2,
  input  logic [DATA_LEN-1:0] src1,
  input  logic [DATA_LEN-1:0] src2,
  input  logic                flush,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [4:0]          out_rd,
  output logic [DATA_LEN-1:0] out_operand1,
  output logic [DATA_LEN-1:0] out_operand2,
  output logic [DATA_LEN-1:0] out_operand3,
  output logic [DATA_LEN-1:0] out_operand4,
  output logic [3:0]          out_alu_op,
  output logic [DATA_LEN-1:0] out_imm,
  output logic                out_jump,
  output logic                out_branch,
  output logic                out_load,
  output logic                out_store,
  output logic                out_wen,
  output logic                out_word,
  output logic                out_ebreak,
  output logic                out_illegal,
  output logic                halt
);

  localparam int CW = $bits(dec_ctrl_t);
  localparam int PW = CW + 5 * DATA_LEN;

  dec_ctrl_t           dec_ctrl, out_ctrl;
  logic [DATA_LEN-1:0] dec_op1, dec_op2, dec_op3, dec_op4, dec_imm;
  logic [PW-1:0]       dec_pkt, main_q, main_n, skid_q, skid_n;
  logic                main_vld, main_vld_n, skid_vld, skid_vld_n;
  logic                halt_q, halt_n, rdy_q, rdy_n;
  logic                accept, consume;

  assign rs1 = in_inst[19:15];
  assign rs2 = in_inst[24:20];

  idu_dec #(.DATA_LEN(DATA_LEN)) u_dec (
    .inst     (in_inst),
    .pc       (in_pc),
    .pc_s     (in_pc_s),
    .src1     (src1),
    .src2     (src2),
    .ctrl     (dec_ctrl),
    .operand1 (dec_op1),
    .operand2 (dec_op2),
    .operand3 (dec_op3),
    .operand4 (dec_op4),
    .imm      (dec_imm)
  );

  assign dec_pkt = {dec_ctrl, dec_op1, dec_op2, dec_op3, dec_op4, dec_imm};

  assign in_ready = (SKID_EN != 0) ? rdy_q : ((!main_vld || out_ready) && !halt_q);
  assign accept   = in_valid && in_ready;
  assign consume  = main_vld && out_ready;

  always_comb begin
    main_vld_n = main_vld;
    main_n     = main_q;
    skid_vld_n = skid_vld;
    skid_n     = skid_q;
    if (!main_vld || consume) begin
      // Main slot frees up: the older skid entry moves up first to keep order.
      if (skid_vld) begin
        main_vld_n = 1'b1;
        main_n     = skid_q;
        skid_vld_n = accept;
        if (accept) skid_n = dec_pkt;
      end else begin
        main_vld_n = accept;
        if (accept) main_n = dec_pkt;
      end
    end else if (accept) begin
      skid_vld_n = 1'b1;
      skid_n     = dec_pkt;
    end
    if (flush) begin
      main_vld_n = 1'b0;
      skid_vld_n = 1'b0;
    end
    halt_n = halt_q || (consume && out_ctrl.ebreak);
    rdy_n  = !skid_vld_n && !halt_n;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_vld <= 1'b0;
      skid_vld <= 1'b0;
      halt_q   <= 1'b0;
      rdy_q    <= 1'b1;
      main_q   <= '0;
      skid_q   <= '0;
    end else begin
      main_vld <= main_vld_n;
      skid_vld <= skid_vld_n;
      halt_q   <= halt_n;
      rdy_q    <= rdy_n;
      main_q   <= main_n;
      skid_q   <= skid_n;
    end
  end

  assign out_ctrl = main_q[PW-1 -: CW];
  assign {out_operand1, out_operand2, out_operand3, out_operand4, out_imm} = main_q[5*DATA_LEN-1:0];

  assign out_valid   = main_vld;
  assign out_rd      = out_ctrl.rd;
  assign out_alu_op  = out_ctrl.alu_op;
  assign out_jump    = out_ctrl.jump;
  assign out_branch  = out_ctrl.branch;
  assign out_load    = out_ctrl.load;
  assign out_store   = out_ctrl.store;
  assign out_wen     = out_ctrl.wen;
  assign out_word    = out_ctrl.word;
  assign out_ebreak  = out_ctrl.ebreak;
  assign out_illegal = out_ctrl.illegal;
  assign halt        = halt_q;

endmodule

// File: tb/tb_idu_pipe.sv
// Directed bench for idu_pipe: a 32-bit skid instance and a 64-bit single-register instance share stimulus.
// Latency: checks taken 1 ns after each rising edge.
// Backpressure: out_ready is driven per step to exercise skid fill, drain, flush and halt.
module tb_idu_pipe;

  logic        clk = 1'b0;
  logic        rst, in_valid, flush, out_ready;
  logic [31:0] in_inst, in_pc, in_pc_s, src1, src2;

  logic        a_in_ready, a_out_valid, a_jump, a_branch, a_load, a_store, a_wen, a_word;
  logic        a_ebreak, a_illegal, a_halt;
  logic [4:0]  a_rs1, a_rs2, a_rd;
  logic [3:0]  a_alu;
  logic [31:0] a_op1, a_op2, a_op3, a_op4, a_imm;

  logic        b_in_ready, b_out_valid, b_jump, b_branch, b_load, b_store, b_wen, b_word;
  logic        b_ebreak, b_illegal, b_halt;
  logic [4:0]  b_rs1, b_rs2, b_rd;
  logic [3:0]  b_alu;
  logic [63:0] b_op1, b_op2, b_op3, b_op4, b_imm;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  idu_pipe #(.DATA_LEN(32), .SKID_EN(1)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready), .in_inst(in_inst),
    .in_pc(in_pc), .in_pc_s(in_pc_s), .rs1(a_rs1), .rs2(a_rs2), .src1(src1), .src2(src2),
    .flush(flush), .out_valid(a_out_valid), .out_ready(out_ready), .out_rd(a_rd),
    .out_operand1(a_op1), .out_operand2(a_op2), .out_operand3(a_op3), .out_operand4(a_op4),
    .out_alu_op(a_alu), .out_imm(a_imm), .out_jump(a_jump), .out_branch(a_branch),
    .out_load(a_load), .out_store(a_store), .out_wen(a_wen), .out_word(a_word),
    .out_ebreak(a_ebreak), .out_illegal(a_illegal), .halt(a_halt)
  );

  idu_pipe #(.DATA_LEN(64), .SKID_EN(0)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready), .in_inst(in_inst),
    .in_pc({32'h0, in_pc}), .in_pc_s({32'h0, in_pc_s}), .rs1(b_rs1), .rs2(b_rs2),
    .src1({32'h0, src1}), .src2({32'h0, src2}),
    .flush(flush), .out_valid(b_out_valid), .out_ready(out_ready), .out_rd(b_rd),
    .out_operand1(b_op1), .out_operand2(b_op2), .out_operand3(b_op3), .out_operand4(b_op4),
    .out_alu_op(b_alu), .out_imm(b_imm), .out_jump(b_jump), .out_branch(b_branch),
    .out_load(b_load), .out_store(b_store), .out_wen(b_wen), .out_word(b_word),
    .out_ebreak(b_ebreak), .out_illegal(b_illegal), .halt(b_halt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  localparam logic [31:0] I1 = 32'h0010_0113;  // addi x2,x0,1
  localparam logic [31:0] I2 = 32'h0020_0193;  // addi x3,x0,2
  localparam logic [31:0] I3 = 32'h0030_0213;  // addi x4,x0,3

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_inst = '0; flush = 1'b0; out_ready = 1'b0;
    in_pc = 32'h8000_0000; in_pc_s = 32'h8000_0004; src1 = '0; src2 = '0;
    tick(); tick();
    chk("rst_out_valid", 64'(a_out_valid), 64'd0);
    chk("rst_halt",      64'(a_halt),      64'd0);
    chk("rst_operand1",  64'(a_op1),       64'd0);
    chk("rst_imm",       64'(a_imm),       64'd0);
    chk("rst_rd",        64'(a_rd),        64'd0);
    chk("rst_wen",       64'(a_wen),       64'd0);
    rst = 1'b0;
    tick();
    chk("post_rst_in_ready", 64'(a_in_ready), 64'd1);

    // addi x1,x0,5
    in_valid = 1'b1; in_inst = 32'h0050_0093; src1 = '0; src2 = 32'h1234; out_ready = 1'b1;
    #1;
    chk("addi_rs1", 64'(a_rs1), 64'd0);
    chk("addi_rs2", 64'(a_rs2), 64'd5);
    tick(); in_valid = 1'b0;
    chk("addi_valid",    64'(a_out_valid), 64'd1);
    chk("addi_operand1", 64'(a_op1),       64'd0);
    chk("addi_operand2", 64'(a_op2),       64'd5);
    chk("addi_operand4", 64'(a_op4),       64'd5);
    chk("addi_wen",      64'(a_wen),       64'd1);
    chk("addi_rd",       64'(a_rd),        64'd1);
    chk("addi_alu",      64'(a_alu),       64'd0);

    // jal x1,8
    in_valid = 1'b1; in_inst = 32'h0080_00EF; src1 = 32'hDEAD;
    tick(); in_valid = 1'b0;
    chk("jal_jump",     64'(a_jump), 64'd1);
    chk("jal_operand1", 64'(a_op1),  64'h8000_0004);
    chk("jal_operand2", 64'(a_op2),  64'd0);
    chk("jal_operand3", 64'(a_op3),  64'h8000_0000);
    chk("jal_operand4", 64'(a_op4),  64'd8);
    chk("jal_wen",      64'(a_wen),  64'd1);
    tick();
    chk("jal_drained", 64'(a_out_valid), 64'd0);

    // three back-to-back with the consumer stalled for three edges
    out_ready = 1'b0; in_valid = 1'b1; in_inst = I1;
    tick();
    chk("skid_1st_valid",    64'(a_out_valid), 64'd1);
    chk("skid_1st_rd",       64'(a_rd),        64'd2);
    chk("skid_1st_in_ready", 64'(a_in_ready),  64'd1);
    in_inst = I2;
    tick();
    chk("skid_2nd_in_ready", 64'(a_in_ready), 64'd0);
    chk("skid_hold_op2",     64'(a_op2),      64'd1);
    in_inst = I3;
    tick();
    chk("skid_3rd_in_ready", 64'(a_in_ready), 64'd0);
    chk("skid_hold_rd",      64'(a_rd),       64'd2);
    out_ready = 1'b1;
    tick();
    chk("drain_2_rd",       64'(a_rd),       64'd3);
    chk("drain_2_in_ready", 64'(a_in_ready), 64'd1);
    tick(); in_valid = 1'b0;
    chk("drain_3_valid", 64'(a_out_valid), 64'd1);
    chk("drain_3_rd",    64'(a_rd),        64'd4);
    tick();
    chk("drain_done", 64'(a_out_valid), 64'd0);

    // flush with main and skid full and a pending input
    out_ready = 1'b0; in_valid = 1'b1; in_inst = I1;
    tick(); in_inst = I2;
    tick();
    chk("flush_full_in_ready", 64'(a_in_ready), 64'd0);
    flush = 1'b1; in_inst = I3;
    tick(); flush = 1'b0; in_valid = 1'b0;
    chk("flush_valid",    64'(a_out_valid), 64'd0);
    chk("flush_in_ready", 64'(a_in_ready),  64'd1);
    out_ready = 1'b1;
    tick();
    chk("flush_no_emit", 64'(a_out_valid), 64'd0);

    // flush on the same edge as an accept drops the new instruction too
    out_ready = 1'b0; in_valid = 1'b1; in_inst = I1;
    tick(); in_inst = I2; flush = 1'b1;
    tick(); flush = 1'b0; in_valid = 1'b0;
    chk("flush_accept_valid", 64'(a_out_valid), 64'd0);
    out_ready = 1'b1;
    tick();
    chk("flush_accept_no_emit", 64'(a_out_valid), 64'd0);

    // illegal and width-dependent encodings
    in_valid = 1'b1; in_inst = 32'hFFFF_FFFF;
    tick();
    chk("ones_illegal",   64'(a_illegal), 64'd1);
    chk("ones_wen",       64'(a_wen),     64'd0);
    chk("ones_b_illegal", 64'(b_illegal), 64'd1);
    in_inst = 32'h0000_003B;
    tick();
    chk("addw32_illegal", 64'(a_illegal),   64'd1);
    chk("addw64_valid",   64'(b_out_valid), 64'd1);
    chk("addw64_illegal", 64'(b_illegal),   64'd0);
    chk("addw64_word",    64'(b_word),      64'd1);
    in_inst = 32'h0000_3003;  // ld x0,0(x0)
    tick();
    chk("ld32_illegal", 64'(a_illegal), 64'd1);
    chk("ld32_load",    64'(a_load),    64'd0);
    chk("ld64_load",    64'(b_load),    64'd1);
    in_inst = 32'h0000_2063;  // branch funct3=010
    tick();
    chk("br010_illegal", 64'(a_illegal), 64'd1);
    in_inst = 32'hFFF0_0093;  // addi x1,x0,-1
    tick();
    chk("neg_op2_32", 64'(a_op2), 64'hFFFF_FFFF);
    chk("neg_op2_64", b_op2,      64'hFFFF_FFFF_FFFF_FFFF);
    in_inst = 32'h1234_50B7;  // lui x1,0x12345
    tick();
    chk("lui_operand1", 64'(a_op1), 64'd0);
    chk("lui_operand2", 64'(a_op2), 64'h1234_5000);
    chk("lui_alu",      64'(a_alu), 64'd10);
    in_inst = 32'h4020_81B3; src1 = 32'h11; src2 = 32'h22;  // sub x3,x1,x2
    tick();
    chk("sub_alu",      64'(a_alu), 64'd1);
    chk("sub_operand1", 64'(a_op1), 64'h11);
    chk("sub_operand2", 64'(a_op2), 64'h22);
    chk("sub_imm",      64'(a_imm), 64'd0);

    // ebreak -> sticky halt
    in_inst = 32'h0010_0073;
    tick(); in_valid = 1'b0;
    chk("ebreak_flag", 64'(a_ebreak), 64'd1);
    chk("ebreak_imm",  64'(a_imm),    64'd0);
    chk("ebreak_halt_not_yet", 64'(a_halt), 64'd0);
    tick();
    chk("halt_set",      64'(a_halt),     64'd1);
    chk("halt_in_ready", 64'(a_in_ready), 64'd0);
    in_valid = 1'b1; in_inst = I1; flush = 1'b1;
    tick(); flush = 1'b0;
    chk("halt_survives_flush", 64'(a_halt),     64'd1);
    chk("halt_in_ready_2",     64'(a_in_ready), 64'd0);
    tick();
    chk("halt_no_accept", 64'(a_out_valid), 64'd0);
    rst = 1'b1; flush = 1'b1;
    tick();
    chk("rst_clears_halt", 64'(a_halt),      64'd0);
    chk("rst_dominates",   64'(a_out_valid), 64'd0);
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
    tick();
    chk("rst_release_in_ready", 64'(a_in_ready), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/idu_pipe.md
IDU_PIPE -- requirements
Module: idu_pipe

Interface
REQ-001 SHALL have parameter DATA_LEN, default 32, datapath width (32 or 64; 64 enables RV64I word ops).
REQ-002 SHALL have parameter SKID_EN, default 1: 1 = two-entry (main+skid) buffer with registered in_ready, 0 = single register.
REQ-003 SHALL have ports: clk input 1 clock; rst input 1 reset, synchronous, active-high.
REQ-004 SHALL have ports: in_valid input 1, in_ready output 1, in_inst input 32, in_pc input DATA_LEN, in_pc_s input DATA_LEN (PC+4).
REQ-005 SHALL have ports: rs1 output 5 and rs2 output 5, combinational from in_inst, for the register-file read; src1 input DATA_LEN and src2 input DATA_LEN, read data.
REQ-006 SHALL have port flush input 1, which drops all buffered and incoming instructions.
REQ-007 SHALL have ports: out_valid output 1, out_ready input 1, out_rd output 5, out_operand1..out_operand4 output DATA_LEN each, out_alu_op output 4, out_imm output DATA_LEN.
REQ-008 SHALL have flag outputs, 1 bit each: out_jump, out_branch, out_load, out_store, out_wen, out_word (RV64 *W op), out_ebreak, out_illegal; plus halt output 1.

Function
REQ-009 SHALL accept an instruction on in_valid&&in_ready, capturing in_inst, in_pc, in_pc_s, src1 and src2 in the same cycle; latency to out_valid SHALL be 1 cycle.
REQ-010 SHALL decode immediates I/S/B/U/J, sign-extended to DATA_LEN; out_imm SHALL be 0 for R-type and SYSTEM.
REQ-011 out_operand1 SHALL be: PC for auipc; PC_S for jal/jalr; 0 for lui; src1 otherwise.
REQ-012 out_operand2 SHALL be: 0 for jal/jalr; imm for I/U/load/store; src2 for R/branch.
REQ-013 out_operand3 SHALL be src1 for jalr and PC otherwise; out_operand4 SHALL be imm for I/U/J/B and 0 otherwise.
REQ-014 out_jump SHALL be jal|jalr; out_wen SHALL be asserted for lui, auipc, jal, jalr, load, OP-IMM and OP (and *-32 ops) when rd!=0.
REQ-015 out_illegal SHALL be set when: inst[1:0]!=2'b11; opcode is unknown; opcode is 0011011/0111011 with DATA_LEN=32; branch funct3 is 010/011; load funct3 is invalid for DATA_LEN; store funct3 exceeds the width. Illegal instructions SHALL force out_wen=0, out_load=0 and out_store=0.
REQ-016 out_ebreak SHALL be asserted only for inst==32'h00100073.
REQ-017 With SKID_EN=1, in_ready SHALL equal !skid_valid, registered; an accept while main is valid and not consumed SHALL fill skid; when main is consumed, skid SHALL move to main in the same edge.
REQ-018 With SKID_EN=0, in_ready SHALL be !out_valid||out_ready.
REQ-019 Simultaneous accept and consume SHALL keep order, with no bubble and no loss.
REQ-020 flush SHALL clear main and skid at the edge; an input accepted in the flush cycle SHALL be dropped; out_valid SHALL be 0 the next cycle.
REQ-021 halt SHALL set, sticky, at the edge where an out_ebreak instruction is consumed; while halt=1, in_ready SHALL be 0; flush SHALL NOT clear halt.
REQ-022 Payload outputs SHALL hold stable while out_valid&&!out_ready.

Reset
REQ-023 On rst: out_valid=0, skid_valid=0, halt=0, and every payload output and flag = 0; in_ready SHALL be 1 the cycle after rst deasserts.
REQ-024 rst SHALL dominate flush and any handshake in the same cycle, and SHALL discard an in-flight instruction.

Structure
REQ-025 Package idu_pkg SHALL hold: the opcode constants, the ALU_OP enumeration (ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, LUI_PASS), the imm-type enum, and the decoded-bundle struct.
REQ-026 Combinational decode SHALL be sub-module idu_dec (inst, pc, pc_s, src1, src2 -> bundle); idu_pipe SHALL hold the buffers, the handshake and halt.

Verification
REQ-027 Bench SHALL cover: 0x00500093 (addi x1,x0,5), src1=0, pc=0x80000000 -> next cycle out_operand1=0, out_operand2=5, out_wen=1, out_rd=1.
REQ-028 Bench SHALL cover: 0x008000EF (jal x1,8), pc=0x80000000 -> out_jump=1, out_operand1=0x80000004, out_operand3=0x80000000, out_operand4=8.
REQ-029 Bench SHALL cover: three back-to-back instructions with out_ready=0 for 3 cycles (SKID_EN=1) -> in_ready drops after the 2nd accept; drain order 1,2,3; none lost.
REQ-030 Bench SHALL cover: flush asserted with main+skid full and in_valid=1 -> out_valid=0 next cycle and nothing emitted.
REQ-031 Bench SHALL cover: 0xFFFFFFFF -> out_illegal=1, out_wen=0; 0x0000003B with DATA_LEN=32 -> out_illegal=1; with DATA_LEN=64 -> out_word=1.
REQ-032 Bench SHALL cover: 0x00100073 consumed -> halt=1 next cycle and in_ready=0 until rst.
